// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forward-select encodings, register $0 and the in-flight scoreboard entry.
package hazard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic       load;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, rd: REG_ZERO, wr: 1'b0, load: 1'b0};

endpackage

// File: rtl/hazard_src_match.sv
// Compares one decode source register against the EX, MEM and WB scoreboard entries.
module hazard_src_match
   import hazard_pkg::*;
(
   input  logic [4:0] src,
   input  logic       use_src,
   input  sb_entry_t  sb_ex,
   input  sb_entry_t  sb_mem,
   input  sb_entry_t  sb_wb,
   output logic       match_ex,
   output logic       match_mem,
   output logic       load_ex
);

   function automatic logic hit(input sb_entry_t e, input logic [4:0] s, input logic u);
      return u && e.valid && e.wr && (e.rd == s) && (s != REG_ZERO);
   endfunction

   assign match_ex  = hit(sb_ex, src, use_src);
   assign match_mem = hit(sb_mem, src, use_src);
   assign load_ex   = match_ex && sb_ex.load;

   // The register file writes before it reads, so a WB producer never needs action.
   logic unused_wb;
   assign unused_wb = ^sb_wb;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: scoreboard of EX/MEM/WB destinations, forwarding selects, stall/flush.
// Optional macro HAZARD_FORWARDING_EN enables forwarding; without it every dependency stalls.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   id_valid,
   input  logic [4:0]             id_rs,
   input  logic [4:0]             id_rt,
   input  logic                   id_uses_rs,
   input  logic                   id_uses_rt,
   input  logic [4:0]             id_rd,
   input  logic                   id_reg_write,
   input  logic                   id_mem_read,
   input  logic                   ex_branch_taken,
   output logic                   stall,
   output logic                   flush_ifid,
   output logic                   flush_idex,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b,
   output logic [STALL_CNT_W-1:0] stall_count
);

   sb_entry_t sb_ex_p0, sb_mem_p1, sb_wb_p2;
   logic      match_ex_a, match_mem_a, load_ex_a;
   logic      match_ex_b, match_mem_b, load_ex_b;
   logic      hazard;
   logic      bubble;

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
   endfunction

   hazard_src_match u_match_rs (
      .src       (id_rs),
      .use_src   (id_uses_rs && id_valid),
      .sb_ex     (sb_ex_p0),
      .sb_mem    (sb_mem_p1),
      .sb_wb     (sb_wb_p2),
      .match_ex  (match_ex_a),
      .match_mem (match_mem_a),
      .load_ex   (load_ex_a)
   );

   hazard_src_match u_match_rt (
      .src       (id_rt),
      .use_src   (id_uses_rt && id_valid),
      .sb_ex     (sb_ex_p0),
      .sb_mem    (sb_mem_p1),
      .sb_wb     (sb_wb_p2),
      .match_ex  (match_ex_b),
      .match_mem (match_mem_b),
      .load_ex   (load_ex_b)
   );

`ifdef HAZARD_FORWARDING_EN
   assign hazard = load_ex_a || load_ex_b;
`else
   assign hazard = match_ex_a || match_mem_a || match_ex_b || match_mem_b;
   logic unused_load;
   assign unused_load = load_ex_a | load_ex_b;
`endif

   // A taken branch flushes the wrong-path instruction, so it overrides any stall.
   assign stall      = hazard && !ex_branch_taken;
   assign flush_ifid = ex_branch_taken;
   assign flush_idex = ex_branch_taken;
   assign bubble     = stall || ex_branch_taken || !id_valid;

   // ID -> EX -> MEM -> WB scoreboard shift
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_ex_p0.valid  <= 1'b0;
         sb_mem_p1.valid <= 1'b0;
         sb_wb_p2.valid  <= 1'b0;
         stall_count     <= '0;
      end else begin
         sb_wb_p2  <= sb_mem_p1;
         sb_mem_p1 <= sb_ex_p0;
         sb_ex_p0  <= bubble ? SB_BUBBLE
                             : '{valid: 1'b1, rd: id_rd, wr: id_reg_write, load: id_mem_read};
         if (stall)
            stall_count <= sat_inc(stall_count);
      end
   end

`ifdef HAZARD_FORWARDING_EN
   function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem);
      if (m_ex)
         return FWD_MEM;
      else if (m_mem)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   // ID -> EX forward-select registers
   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         fwd_a <= FWD_RF;
         fwd_b <= FWD_RF;
      end else begin
         fwd_a <= fwd_sel(match_ex_a, match_mem_a);
         fwd_b <= fwd_sel(match_ex_b, match_mem_b);
      end
   end
`else
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl; expectations follow the build's HAZARD_FORWARDING_EN setting.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
   logic        ex_branch_taken;
   logic        stall, flush_ifid, flush_idex;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_count;

   hazard_ctrl #(.STALL_CNT_W(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .id_valid        (id_valid),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .id_rd           (id_rd),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .stall           (stall),
      .flush_ifid      (flush_ifid),
      .flush_idex      (flush_idex),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b),
      .stall_count     (stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [4:0] rs, rt;
      logic       urs, urt;
      logic [4:0] rd;
      logic       rw, mr, br;
      logic       e_stall, e_flush;
      logic [1:0] e_fa, e_fb;
      int         e_cnt;
   } vec_t;

   typedef struct {
      logic [1:0] fa, fb;
      int         cnt;
      int         idx;
   } exp_t;

   vec_t tbl[$];
   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input logic v, input int rs, input int rt, input logic urs,
                               input logic urt, input int rd, input logic rw, input logic mr,
                               input logic br, input logic es, input logic ef,
                               input logic [1:0] fa, input logic [1:0] fb, input int cnt);
      vec_t r;
      r.v = v; r.rs = 5'(rs); r.rt = 5'(rt); r.urs = urs; r.urt = urt; r.rd = 5'(rd);
      r.rw = rw; r.mr = mr; r.br = br; r.e_stall = es; r.e_flush = ef;
      r.e_fa = fa; r.e_fb = fb; r.e_cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t r);
      id_valid = r.v; id_rs = r.rs; id_rt = r.rt; id_uses_rs = r.urs; id_uses_rt = r.urt;
      id_rd = r.rd; id_reg_write = r.rw; id_mem_read = r.mr; ex_branch_taken = r.br;
   endtask

   task automatic apply(input vec_t r, input int idx);
      exp_t e;
      @(negedge clk);
      drive(r);
      #1;
      chk("stall", idx, int'(stall), int'(r.e_stall));
      chk("flush_ifid", idx, int'(flush_ifid), int'(r.e_flush));
      chk("flush_idex", idx, int'(flush_idex), int'(r.e_flush));
      e.fa = r.e_fa; e.fb = r.e_fb; e.cnt = r.e_cnt; e.idx = idx;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard[%0d]: queue empty, expected one entry", idx);
      end else begin
         e = sbq.pop_front();
         chk("fwd_a", e.idx, int'(fwd_a), int'(e.fa));
         chk("fwd_b", e.idx, int'(fwd_b), int'(e.fb));
         chk("stall_count", e.idx, int'(stall_count), e.cnt);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t idle;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      reset = 1'b1;
      drive(idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_stall", 0, int'(stall), 0);
      chk("rst_flush_ifid", 0, int'(flush_ifid), 0);
      chk("rst_flush_idex", 0, int'(flush_idex), 0);
      chk("rst_fwd_a", 0, int'(fwd_a), 0);
      chk("rst_fwd_b", 0, int'(fwd_b), 0);
      chk("rst_stall_count", 0, int'(stall_count), 0);

`ifdef HAZARD_FORWARDING_EN
      tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // add $3
      tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0)); // sub $4,$3,$5
      tbl.push_back(idle);
      tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // add $3
      tbl.push_back(idle);
      tbl.push_back(mk(1, 3, 3, 1, 1, 6, 1, 0, 0, 0, 0, 2'b01, 2'b01, 0)); // or $6,$3,$3
      tbl.push_back(mk(1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0)); // lw $8
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1)); // add $9 stalls
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 2'b01, 2'b01, 1));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1)); // addi $0
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1)); // add $1,$0,$0
      tbl.push_back(mk(1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 0, 2'b00, 2'b00, 1)); // lw $8
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 1, 0, 1, 2'b00, 2'b00, 1)); // branch wins
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 2'b01, 2'b01, 1));
      tbl.push_back(mk(1, 5, 9, 1, 1, 10, 1, 0, 0, 0, 0, 2'b00, 2'b10, 1)); // or $10,$5,$9
      tbl.push_back(mk(1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, 2'b01, 2'b01, 1)); // add $10,$9,$9
      tbl.push_back(mk(1, 10, 10, 1, 1, 11, 1, 0, 0, 0, 0, 2'b10, 2'b10, 1)); // youngest wins
      tbl.push_back(mk(1, 11, 4, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1)); // rs unused
`else
      tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0)); // add $3
      tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1)); // sub stalls
      tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2));
      tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2));
      tbl.push_back(mk(1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2)); // lw $8
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3));
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 2'b00, 2'b00, 4));
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4));
      tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4)); // addi $0
      tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4)); // add $1,$0,$0
      tbl.push_back(mk(1, 2, 0, 1, 0, 8, 1, 1, 0, 0, 0, 2'b00, 2'b00, 4)); // lw $8
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 1, 0, 1, 2'b00, 2'b00, 4)); // branch wins
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 2'b00, 2'b00, 5));
      tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, 5));
      tbl.push_back(mk(1, 9, 4, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5)); // rs unused
`endif

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], i + 1);

      // Reset arriving while a dependency stall is active discards all tracking.
      begin
         vec_t prod, cons;
         int   last_cnt;
         last_cnt = tbl[tbl.size() - 1].e_cnt;
         prod = mk(1, 2, 0, 1, 0, 12, 1, 1, 0, 0, 0, 2'b00, 2'b00, last_cnt);
         cons = mk(1, 12, 0, 1, 0, 13, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
         apply(prod, 100);
         @(negedge clk);
         drive(cons);
         #1;
         chk("midrst_stall_before", 101, int'(stall), 1);
         reset = 1'b1;
         @(posedge clk);
         #1;
         chk("midrst_stall_count", 102, int'(stall_count), 0);
         chk("midrst_fwd_a", 102, int'(fwd_a), 0);
         @(negedge clk);
         reset = 1'b0;
         #1;
         chk("midrst_stall_after", 103, int'(stall), 0);
         @(posedge clk);
         #1;
         chk("midrst_fwd_a_after", 104, int'(fwd_a), 0);
         chk("midrst_count_after", 104, int'(stall_count), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
